approx_err_sweep: RTL and testbench
===================================

APPROX_ERR_SWEEP -- requirements
Module: approx_err_sweep

Interface
REQ-001 SHALL have parameter: USE_APPROX, 1, 1 = product taken from the approximate multiplier_4x4 instance; 0 = exact A*B substituted (bench self-check mode).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a full 256-pair sweep.
REQ-005 SHALL have port: busy  output  1  high while a sweep or drain is in progress.
REQ-006 SHALL have port: done  output  1  one-cycle pulse when results become valid.
REQ-007 SHALL have port: err_cnt  output  9  number of pairs with approx != exact (0..256).
REQ-008 SHALL have port: sum_abs_err  output  16  sum of |exact - approx| over all pairs.
REQ-009 SHALL have port: med  output  8  mean error distance = sum_abs_err[15:8].
REQ-010 SHALL have port: max_abs_err  output  8  largest |exact - approx| seen.
REQ-011 SHALL have port: max_a, max_b  output  4 each  operands of the first pair reaching max_abs_err.

Function
REQ-012 SHALL implement FSM states IDLE, SWEEP, DRAIN, DONE.
REQ-013 SHALL leave IDLE only for SWEEP, when start = 1; start in any other state SHALL be ignored.
REQ-014 SHALL, on start acceptance, clear all accumulators and the 8-bit pair index idx to 0.
REQ-015 SHALL, in SWEEP, drive A = idx[7:4], B = idx[3:0] into the multiplier each cycle and increment idx; wrap 255 -> 0 SHALL move to DRAIN.
REQ-016 SHALL register the pair per cycle as a stage-1 entry: valid, A, B, and 8-bit |exact - approx| (exact = A*B, 8-bit unsigned; difference computed 9-bit signed, magnitude kept 8-bit).
REQ-017 SHALL update accumulators from stage 1 one cycle later; SWEEP (256 cycles) plus DRAIN (1 cycle) SHALL account for exactly 256 accumulated pairs.
REQ-018 SHALL increment err_cnt when the magnitude is nonzero; sum_abs_err SHALL NOT saturate (maximum 256*225 = 57600 fits 16 bits).
REQ-019 SHALL update max_abs_err/max_a/max_b only on strictly greater magnitude, so ties keep the earliest idx.
REQ-020 SHALL, with start sampled in cycle 0: busy = 1 in cycles 1..257, DONE state in cycle 258 with done = 1 and busy = 0, and IDLE from cycle 259.
REQ-021 SHALL hold all result outputs stable from DONE until the next accepted start; during a sweep they SHALL show partial accumulations (not valid until done).
REQ-022 SHALL assert start in DONE as ignored; start in the IDLE cycle immediately after DONE SHALL be accepted.

Reset
REQ-023 SHALL, on rst = 1 at a clock edge, enter IDLE and zero idx, stage-1 valid, busy, done, err_cnt, sum_abs_err, max_abs_err, max_a and max_b.
REQ-024 SHALL give rst priority over start in the same cycle; rst mid-sweep SHALL abort without a done pulse.

Structure
REQ-025 SHALL place the state enum, IDX_W = 8, and the ERR_W/SUM_W width constants in shared package approx_mult_pkg.
REQ-026 SHALL instantiate exactly one multiplier_4x4 as its sole sub-module; exact product and error logic SHALL be local.

Verification
REQ-027 SHALL cover: rst held 3 cycles, then released -> all outputs 0, busy = 0, state IDLE.
REQ-028 SHALL cover: USE_APPROX = 0 with start in cycle 0 -> done only in cycle 258; err_cnt = 0, sum_abs_err = 0, max_abs_err = 0, max_a = max_b = 0.
REQ-029 SHALL cover: USE_APPROX = 1 full sweep -> err_cnt, sum_abs_err, med, max_abs_err, max_a, max_b equal to the bench golden model of multiplier_4x4 across all 256 pairs.
REQ-030 SHALL cover: start re-pulsed in cycles 5, 200 and 258 -> ignored; single done at 258; results unchanged.
REQ-031 SHALL cover: rst in cycle 100 of a sweep -> outputs 0 next cycle, no done; a following start runs a full correct sweep.
REQ-032 SHALL cover: start in cycle 259 right after DONE -> accepted, accumulators cleared, second done in cycle 517 with identical results.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// ---------------------------------------------------------------------------
// approx_mult_pkg
// Shared definitions for the approximate-multiplier error sweep:
//   - state_t  : sweep controller states
//   - widths   : pair index, operand, product, error magnitude, counters
//   - err_mag  : magnitude of a 9-bit two's-complement product difference
// ---------------------------------------------------------------------------
package approx_mult_pkg;

    localparam int IDX_W  = 8;   // pair index {A, B}
    localparam int OP_W   = 4;   // multiplier operand width
    localparam int PROD_W = 8;   // 4x4 product width
    localparam int MAG_W  = 8;   // |exact - approx| kept width
    localparam int ERR_W  = 9;   // error count, 0..256
    localparam int SUM_W  = 16;  // sum of magnitudes, max 256*225

    localparam logic [IDX_W-1:0] IDX_LAST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Magnitude of a 9-bit signed difference; the result always fits in
    // 8 bits because both operands of the subtraction are 8-bit unsigned.
    function automatic logic [MAG_W-1:0] err_mag(input logic [PROD_W:0] diff);
        logic [PROD_W:0] pos;
        if (diff[PROD_W]) begin
            pos = 9'd0 - diff;
        end else begin
            pos = diff;
        end
        return pos[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/multiplier_4x4.sv
// ---------------------------------------------------------------------------
// multiplier_4x4
// Approximate unsigned 4x4 multiplier. The two least-significant partial
// product columns (weights 1 and 2) are dropped entirely, including any
// carry they would have produced. The result is therefore never larger
// than the exact product and differs from it by at most 5.
// Ports:
//   a, b : 4-bit unsigned operands
//   p    : 8-bit approximate product (combinational)
// ---------------------------------------------------------------------------
module multiplier_4x4
    import approx_mult_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] pp0_s;
    logic [PROD_W-1:0] pp1_s;
    logic [PROD_W-1:0] pp2_s;
    logic [PROD_W-1:0] pp3_s;

    // Partial-product rows with the weight-1 and weight-2 bits removed
    always_comb begin
        pp0_s = 8'd0;
        pp1_s = 8'd0;
        pp2_s = 8'd0;
        pp3_s = 8'd0;
        // row b[0]: keep a[3:2] (weights 4, 8)
        if (b[0]) begin
            pp0_s = {2'b00, a[3:2], 2'b00};
        end else begin
            pp0_s = 8'd0;
        end
        // row b[1]: keep a[3:1] (weights 4..16)
        if (b[1]) begin
            pp1_s = {3'b000, a[3:1], 2'b00};
        end else begin
            pp1_s = 8'd0;
        end
        if (b[2]) begin
            pp2_s = {2'b00, a, 2'b00};
        end else begin
            pp2_s = 8'd0;
        end
        if (b[3]) begin
            pp3_s = {1'b0, a, 3'b000};
        end else begin
            pp3_s = 8'd0;
        end
    end

    assign p = pp0_s + pp1_s + pp2_s + pp3_s;

endmodule

// File: rtl/approx_err_sweep.sv
// ---------------------------------------------------------------------------
// approx_err_sweep
// Exhaustively drives all 256 operand pairs through one multiplier_4x4 and
// accumulates error statistics against the exact product.
// Parameters:
//   USE_APPROX : 1 = use multiplier_4x4 result, 0 = substitute exact A*B
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle sweep request (honoured only in IDLE)
//   busy        : sweep or drain in progress
//   done        : one-cycle pulse when results are valid
//   err_cnt     : number of pairs with a nonzero error
//   sum_abs_err : sum of |exact - approx|
//   med         : mean error distance, sum_abs_err / 256
//   max_abs_err : largest |exact - approx|
//   max_a/max_b : operands of the earliest pair reaching max_abs_err
// Timing, start sampled in cycle 0: SWEEP in cycles 1..256 (idx 0..255),
// DRAIN in 257 (last stage-1 entry accumulated), DONE in 258.
// ---------------------------------------------------------------------------
module approx_err_sweep
    import approx_mult_pkg::*;
#(
    parameter int USE_APPROX = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [7:0]       med,
    output logic [MAG_W-1:0] max_abs_err,
    output logic [OP_W-1:0]  max_a,
    output logic [OP_W-1:0]  max_b
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic               accept_s;

    logic [OP_W-1:0]    op_a_s;
    logic [OP_W-1:0]    op_b_s;
    logic [PROD_W-1:0]  approx_p_s;
    logic [PROD_W-1:0]  exact_p_s;
    logic [PROD_W-1:0]  prod_s;
    logic [PROD_W:0]    diff_s;
    logic [MAG_W-1:0]   mag_s;

    logic               s1_valid_r;
    logic [OP_W-1:0]    s1_a_r;
    logic [OP_W-1:0]    s1_b_r;
    logic [MAG_W-1:0]   s1_mag_r;

    logic               busy_r;
    logic               done_r;
    logic [ERR_W-1:0]   err_cnt_r;
    logic [SUM_W-1:0]   sum_r;
    logic [MAG_W-1:0]   max_r;
    logic [OP_W-1:0]    max_a_r;
    logic [OP_W-1:0]    max_b_r;

    assign accept_s = (state_r == IDLE) && start;
    assign op_a_s   = idx_r[7:4];
    assign op_b_s   = idx_r[3:0];

    multiplier_4x4 u_mult (
        .a (op_a_s),
        .b (op_b_s),
        .p (approx_p_s)
    );

    assign exact_p_s = {4'b0000, op_a_s} * {4'b0000, op_b_s};
    assign prod_s    = (USE_APPROX != 0) ? approx_p_s : exact_p_s;
    // 9-bit difference so that an approximation above exact is also handled
    assign diff_s    = {1'b0, exact_p_s} - {1'b0, prod_s};
    assign mag_s     = err_mag(diff_s);

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SWEEP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SWEEP: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = SWEEP;
                end
            end
            DRAIN:   state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered busy/done derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == SWEEP) || (state_nxt_s == DRAIN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Pair index: cleared on accept, advances every SWEEP cycle, wraps to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= 8'd0;
        end else if (accept_s) begin
            idx_r <= 8'd0;
        end else if (state_r == SWEEP) begin
            idx_r <= idx_r + 8'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Stage 1: capture the pair and its error magnitude
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= 4'd0;
            s1_b_r     <= 4'd0;
            s1_mag_r   <= 8'd0;
        end else begin
            s1_valid_r <= (state_r == SWEEP);
            s1_a_r     <= op_a_s;
            s1_b_r     <= op_b_s;
            s1_mag_r   <= mag_s;
        end
    end

    // Accumulators fed from stage 1; strict compare keeps the earliest max
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 9'd0;
            sum_r     <= 16'd0;
            max_r     <= 8'd0;
            max_a_r   <= 4'd0;
            max_b_r   <= 4'd0;
        end else if (accept_s) begin
            err_cnt_r <= 9'd0;
            sum_r     <= 16'd0;
            max_r     <= 8'd0;
            max_a_r   <= 4'd0;
            max_b_r   <= 4'd0;
        end else if (s1_valid_r) begin
            err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, (s1_mag_r != 8'd0)};
            sum_r     <= sum_r + {{(SUM_W-MAG_W){1'b0}}, s1_mag_r};
            if (s1_mag_r > max_r) begin
                max_r   <= s1_mag_r;
                max_a_r <= s1_a_r;
                max_b_r <= s1_b_r;
            end else begin
                max_r   <= max_r;
                max_a_r <= max_a_r;
                max_b_r <= max_b_r;
            end
        end else begin
            err_cnt_r <= err_cnt_r;
            sum_r     <= sum_r;
            max_r     <= max_r;
            max_a_r   <= max_a_r;
            max_b_r   <= max_b_r;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign err_cnt     = err_cnt_r;
    assign sum_abs_err = sum_r;
    assign med         = sum_r[15:8];
    assign max_abs_err = max_r;
    assign max_a       = max_a_r;
    assign max_b       = max_b_r;

endmodule

// File: tb/tb_approx_err_sweep.sv
// ---------------------------------------------------------------------------
// tb_approx_err_sweep
// Two instances share clk/rst/start: one with the approximate multiplier,
// one in exact mode. A per-cycle history of outputs is recorded while a
// start/reset plan is replayed, then compared against a golden model of
// the approximate multiplier computed from its bit-level definition.
// ---------------------------------------------------------------------------
module tb_approx_err_sweep;

    localparam int MAXC = 600;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;

    logic       busy_a, done_a, busy_e, done_e;
    logic [8:0] err_a, err_e;
    logic [15:0] sum_a, sum_e;
    logic [7:0] med_a, med_e, max_a_v, max_e_v;
    logic [3:0] ma_a, mb_a, ma_e, mb_e;

    approx_err_sweep #(.USE_APPROX(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
        .err_cnt(err_a), .sum_abs_err(sum_a), .med(med_a),
        .max_abs_err(max_a_v), .max_a(ma_a), .max_b(mb_a)
    );

    approx_err_sweep #(.USE_APPROX(0)) dut_e (
        .clk(clk), .rst(rst), .start(start), .busy(busy_e), .done(done_e),
        .err_cnt(err_e), .sum_abs_err(sum_e), .med(med_e),
        .max_abs_err(max_e_v), .max_a(ma_e), .max_b(mb_e)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit         start_plan [MAXC];
    bit         rst_plan   [MAXC];
    logic       h_busy [MAXC];
    logic       h_done [MAXC];
    logic [8:0] h_err  [MAXC];
    logic [15:0] h_sum [MAXC];
    logic [7:0] h_med  [MAXC];
    logic [7:0] h_max  [MAXC];
    logic [3:0] h_ma   [MAXC];
    logic [3:0] h_mb   [MAXC];
    logic       e_done [MAXC];
    logic [8:0] e_err  [MAXC];
    logic [15:0] e_sum [MAXC];
    logic [7:0] e_max  [MAXC];
    logic [3:0] e_ma   [MAXC];
    logic [3:0] e_mb   [MAXC];

    // golden prefix statistics: index k = after the first k pairs
    int g_err [257];
    int g_sum [257];
    int g_max [257];
    int g_ma  [257];
    int g_mb  [257];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Approximate product: sum of partial products a_i*b_j*2^(i+j), i+j >= 2
    function automatic int approx_model(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if ((i + j >= 2) && a[i] && b[j]) p += (1 << (i + j));
            end
        end
        return p;
    endfunction

    task automatic build_golden();
        int e;
        g_err[0] = 0; g_sum[0] = 0; g_max[0] = 0; g_ma[0] = 0; g_mb[0] = 0;
        for (int k = 0; k < 256; k++) begin
            e = (k / 16) * (k % 16) - approx_model(k / 16, k % 16);
            if (e < 0) e = -e;
            g_err[k+1] = g_err[k] + ((e != 0) ? 1 : 0);
            g_sum[k+1] = g_sum[k] + e;
            if (e > g_max[k]) begin
                g_max[k+1] = e; g_ma[k+1] = k / 16; g_mb[k+1] = k % 16;
            end else begin
                g_max[k+1] = g_max[k]; g_ma[k+1] = g_ma[k]; g_mb[k+1] = g_mb[k];
            end
        end
    endtask

    task automatic clear_plans();
        for (int c = 0; c < MAXC; c++) begin
            start_plan[c] = 1'b0;
            rst_plan[c]   = 1'b0;
        end
    endtask

    // Replay the plan: record cycle-c outputs, then drive inputs sampled at end of cycle c
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            h_busy[c] = busy_a; h_done[c] = done_a; h_err[c] = err_a;
            h_sum[c] = sum_a; h_med[c] = med_a; h_max[c] = max_a_v;
            h_ma[c] = ma_a; h_mb[c] = mb_a;
            e_done[c] = done_e; e_err[c] = err_e; e_sum[c] = sum_e;
            e_max[c] = max_e_v; e_ma[c] = ma_e; e_mb[c] = mb_e;
            start = start_plan[c];
            rst   = rst_plan[c];
            @(posedge clk);
        end
    endtask

    function automatic int count_done(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (h_done[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_busy(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (h_busy[c] === 1'b1) n++;
        return n;
    endfunction

    task automatic check_final(input string tag, input int c);
        check_eq({tag, "_err_cnt"}, 32'(h_err[c]), g_err[256]);
        check_eq({tag, "_sum"},     32'(h_sum[c]), g_sum[256]);
        check_eq({tag, "_med"},     32'(h_med[c]), g_sum[256] / 256);
        check_eq({tag, "_max"},     32'(h_max[c]), g_max[256]);
        check_eq({tag, "_max_a"},   32'(h_ma[c]),  g_ma[256]);
        check_eq({tag, "_max_b"},   32'(h_mb[c]),  g_mb[256]);
    endtask

    task automatic check_zero(input string tag, input int c);
        check_eq({tag, "_busy"},    32'(h_busy[c]), 0);
        check_eq({tag, "_done"},    32'(h_done[c]), 0);
        check_eq({tag, "_err_cnt"}, 32'(h_err[c]),  0);
        check_eq({tag, "_sum"},     32'(h_sum[c]),  0);
        check_eq({tag, "_med"},     32'(h_med[c]),  0);
        check_eq({tag, "_max"},     32'(h_max[c]),  0);
        check_eq({tag, "_max_a"},   32'(h_ma[c]),   0);
        check_eq({tag, "_max_b"},   32'(h_mb[c]),   0);
    endtask

    initial begin
        int pc;
        int s;
        build_golden();

        // Reset held three cycles, then idle
        clear_plans();
        rst_plan[0] = 1'b1; rst_plan[1] = 1'b1; rst_plan[2] = 1'b1;
        run(6);
        check_zero("rst_c3", 3);
        check_zero("rst_c5", 5);
        check_eq("rst_exact_busy", 32'(busy_e), 0);

        // Full sweep with ignored starts, then immediate restart in cycle 259
        clear_plans();
        start_plan[0] = 1'b1;
        start_plan[5] = 1'b1; start_plan[200] = 1'b1; start_plan[258] = 1'b1;
        for (int i = 0; i < 3; i++) start_plan[$urandom_range(257, 1)] = 1'b1;
        start_plan[259] = 1'b1;
        run(530);
        pc = $urandom_range(258, 3);
        check_eq("sw_busy_c0", 32'(h_busy[0]), 0);
        check_eq("sw_busy_cycles", count_busy(1, 257), 257);
        check_eq("sw_done_c258", 32'(h_done[258]), 1);
        check_eq("sw_done_count1", count_done(0, 258), 1);
        check_eq("sw_busy_c258", 32'(h_busy[258]), 0);
        check_eq("sw_busy_c259", 32'(h_busy[259]), 0);
        check_final("sw1", 258);
        check_eq("sw_partial_err", 32'(h_err[pc]), g_err[pc-2]);
        check_eq("sw_partial_sum", 32'(h_sum[pc]), g_sum[pc-2]);
        check_eq("sw_partial_max", 32'(h_max[pc]), g_max[pc-2]);
        check_final("sw_hold", 259);
        check_eq("sw_clear_err", 32'(h_err[260]), 0);
        check_eq("sw_clear_sum", 32'(h_sum[260]), 0);
        check_eq("sw_clear_max", 32'(h_max[260]), 0);
        check_eq("sw_busy_cycles2", count_busy(260, 516), 257);
        check_eq("sw_done_count2", count_done(259, 529), 1);
        check_eq("sw_done_c517", 32'(h_done[517]), 1);
        check_final("sw2", 517);
        check_final("sw2_hold", 520);
        check_eq("ex_done_c258", 32'(e_done[258]), 1);
        check_eq("ex_done_c257", 32'(e_done[257]), 0);
        check_eq("ex_err_cnt", 32'(e_err[258]), 0);
        check_eq("ex_sum", 32'(e_sum[258]), 0);
        check_eq("ex_max", 32'(e_max[258]), 0);
        check_eq("ex_max_a", 32'(e_ma[258]), 0);
        check_eq("ex_max_b", 32'(e_mb[258]), 0);
        check_eq("ex_done_c517", 32'(e_done[517]), 1);

        // Reset mid-sweep (start in the same cycle must lose), then a fresh sweep
        clear_plans();
        start_plan[0] = 1'b1;
        rst_plan[100] = 1'b1;
        start_plan[100] = 1'b1;
        s = $urandom_range(110, 102);
        start_plan[s] = 1'b1;
        run(s + 262);
        check_eq("ab_partial_nonzero", 32'(h_sum[100] != 16'd0), 1);
        check_zero("ab_c101", 101);
        check_eq("ab_no_done", count_done(0, s), 0);
        check_eq("ab_idle_before", 32'(h_busy[s]), 0);
        check_eq("ab_done_count", count_done(s, s + 261), 1);
        check_eq("ab_done_at", 32'(h_done[s + 258]), 1);
        check_final("ab", s + 258);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
